// File: rtl/if_stage.sv
// Instruction-fetch stage: PC, fetch request FSM, skid buffer and IF/ID register.
// State | meaning: IDLE reset hold / FETCH request at pc / DRAIN discard stale reply / STALL skid full, decode frozen
module if_stage #(
    parameter int WORD_LEN = 16,
    parameter int PC_LEN   = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                freeze,
    input  logic                br_taken,
    input  logic [PC_LEN-1:0]   br_addr,
    input  logic [WORD_LEN-1:0] imem_rdata,
    input  logic                imem_ready,
    output logic                imem_req,
    output logic [PC_LEN-1:0]   imem_addr,
    output logic [WORD_LEN-1:0] instruction_out,
    output logic [PC_LEN-1:0]   pc_out,
    output logic                valid_out
);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, STALL} state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic [PC_LEN-1:0]   r_pc;
    logic [PC_LEN-1:0]   r_drain_addr;
    logic [WORD_LEN-1:0] r_skid_instr;
    logic [PC_LEN-1:0]   r_skid_pc;
    logic                r_skid_valid;
    logic [WORD_LEN-1:0] r_instr;
    logic [PC_LEN-1:0]   r_pc_out;
    logic                r_valid;

    logic [PC_LEN-1:0]   w_pc_inc;
    logic [PC_LEN-1:0]   w_pc_next;
    logic                w_ifid_ld;
    logic [WORD_LEN-1:0] w_ifid_instr;
    logic [PC_LEN-1:0]   w_ifid_pc;
    logic                w_ifid_valid;
    logic                w_skid_ld;
    logic                w_skid_clr;
    logic                w_drain_ld;

    assign w_pc_inc = r_pc + {{(PC_LEN-1){1'b0}}, 1'b1};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_pc_next    = r_pc;
        w_ifid_ld    = !freeze || br_taken;
        w_ifid_instr = '0;
        w_ifid_pc    = '0;
        w_ifid_valid = 1'b0;
        w_skid_ld    = 1'b0;
        w_skid_clr   = 1'b0;
        w_drain_ld   = 1'b0;
        case (r_state)
            IDLE: begin
                w_next_state = FETCH;
                if (br_taken) w_pc_next = br_addr;
            end
            FETCH: begin
                if (br_taken) begin
                    w_pc_next  = br_addr;
                    w_skid_clr = 1'b1;
                    if (!imem_ready) begin
                        w_next_state = DRAIN;
                        w_drain_ld   = 1'b1;
                    end
                end else if (imem_ready) begin
                    w_pc_next = w_pc_inc;
                    if (freeze) begin
                        w_skid_ld    = 1'b1;
                        w_next_state = STALL;
                    end else begin
                        w_ifid_instr = imem_rdata;
                        w_ifid_pc    = w_pc_inc;
                        w_ifid_valid = 1'b1;
                    end
                end
            end
            DRAIN: begin
                // The outstanding reply belongs to a squashed path; only the pc follows new branches.
                if (br_taken) begin
                    w_pc_next  = br_addr;
                    w_skid_clr = 1'b1;
                end
                if (imem_ready) w_next_state = FETCH;
            end
            STALL: begin
                if (br_taken) begin
                    w_pc_next    = br_addr;
                    w_skid_clr   = 1'b1;
                    w_next_state = FETCH;
                end else if (!freeze) begin
                    w_ifid_instr = r_skid_instr;
                    w_ifid_pc    = r_skid_pc;
                    w_ifid_valid = r_skid_valid;
                    w_skid_clr   = 1'b1;
                    w_next_state = FETCH;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pc         <= '0;
            r_drain_addr <= '0;
            r_skid_instr <= '0;
            r_skid_pc    <= '0;
            r_skid_valid <= 1'b0;
            r_instr      <= '0;
            r_pc_out     <= '0;
            r_valid      <= 1'b0;
        end else begin
            r_pc <= w_pc_next;
            if (w_drain_ld) r_drain_addr <= r_pc;
            if (w_skid_ld) begin
                r_skid_instr <= imem_rdata;
                r_skid_pc    <= w_pc_inc;
                r_skid_valid <= 1'b1;
            end else if (w_skid_clr) begin
                r_skid_valid <= 1'b0;
            end
            if (w_ifid_ld) begin
                r_instr  <= w_ifid_instr;
                r_pc_out <= w_ifid_pc;
                r_valid  <= w_ifid_valid;
            end
        end
    end

    assign imem_req        = (r_state == FETCH) || (r_state == DRAIN);
    assign imem_addr       = (r_state == DRAIN) ? r_drain_addr : r_pc;
    assign instruction_out = r_instr;
    assign pc_out          = r_pc_out;
    assign valid_out       = r_valid;

endmodule

// File: tb/tb_if_stage.sv
// Directed vector bench for if_stage; memory returns address + 0x100.
module tb_if_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        freeze = 1'b0;
    logic        br_taken = 1'b0;
    logic [15:0] br_addr = '0;
    logic [15:0] imem_rdata;
    logic        imem_ready = 1'b0;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic [15:0] instruction_out;
    logic [15:0] pc_out;
    logic        valid_out;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    assign imem_rdata = imem_addr + 16'h0100;

    if_stage #(.WORD_LEN(16), .PC_LEN(16)) dut (
        .clk(clk), .rst(rst), .freeze(freeze), .br_taken(br_taken), .br_addr(br_addr),
        .imem_rdata(imem_rdata), .imem_ready(imem_ready), .imem_req(imem_req),
        .imem_addr(imem_addr), .instruction_out(instruction_out), .pc_out(pc_out),
        .valid_out(valid_out)
    );

    typedef struct {
        logic        fr;
        logic        br;
        logic [15:0] ba;
        logic        rdy;
        logic        req;
        logic [15:0] addr;
        logic        vld;
        logic [15:0] ins;
        logic [15:0] pco;
    } vec_t;

    vec_t tv[$];

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s [vec %0d]: got 0x%0h, expected 0x%0h", name, idx, act, exp);
        end
    endtask

    task automatic step(input int idx, input vec_t v);
        freeze = v.fr; br_taken = v.br; br_addr = v.ba; imem_ready = v.rdy;
        #1;
        check("imem_req", idx, {31'd0, imem_req}, {31'd0, v.req});
        check("imem_addr", idx, {16'd0, imem_addr}, {16'd0, v.addr});
        @(posedge clk);
        #1;
        check("valid_out", idx, {31'd0, valid_out}, {31'd0, v.vld});
        check("instruction_out", idx, {16'd0, instruction_out}, {16'd0, v.ins});
        check("pc_out", idx, {16'd0, pc_out}, {16'd0, v.pco});
        @(negedge clk);
    endtask

    initial begin
        //             fr  br  br_addr   rdy  req  addr      vld  instr     pc_out
        tv.push_back('{0, 0, 16'h0000, 1, 0, 16'h0000, 0, 16'h0000, 16'h0000}); // IDLE
        tv.push_back('{0, 0, 16'h0000, 1, 1, 16'h0000, 1, 16'h0100, 16'h0001});
        tv.push_back('{0, 0, 16'h0000, 1, 1, 16'h0001, 1, 16'h0101, 16'h0002});
        tv.push_back('{0, 0, 16'h0000, 1, 1, 16'h0002, 1, 16'h0102, 16'h0003});
        tv.push_back('{0, 0, 16'h0000, 0, 1, 16'h0003, 0, 16'h0000, 16'h0000}); // ready every third
        tv.push_back('{0, 0, 16'h0000, 0, 1, 16'h0003, 0, 16'h0000, 16'h0000});
        tv.push_back('{0, 0, 16'h0000, 1, 1, 16'h0003, 1, 16'h0103, 16'h0004});
        tv.push_back('{0, 0, 16'h0000, 0, 1, 16'h0004, 0, 16'h0000, 16'h0000});
        tv.push_back('{0, 0, 16'h0000, 0, 1, 16'h0004, 0, 16'h0000, 16'h0000});
        tv.push_back('{0, 0, 16'h0000, 1, 1, 16'h0004, 1, 16'h0104, 16'h0005});
        tv.push_back('{1, 0, 16'h0000, 1, 1, 16'h0005, 1, 16'h0104, 16'h0005}); // skid 0x105
        tv.push_back('{1, 0, 16'h0000, 1, 0, 16'h0006, 1, 16'h0104, 16'h0005}); // STALL
        tv.push_back('{1, 0, 16'h0000, 1, 0, 16'h0006, 1, 16'h0104, 16'h0005});
        tv.push_back('{0, 0, 16'h0000, 1, 0, 16'h0006, 1, 16'h0105, 16'h0006}); // release skid
        tv.push_back('{0, 0, 16'h0000, 1, 1, 16'h0006, 1, 16'h0106, 16'h0007});
        tv.push_back('{0, 1, 16'h0005, 1, 1, 16'h0007, 0, 16'h0000, 16'h0000}); // branch, ready
        tv.push_back('{0, 1, 16'h0040, 0, 1, 16'h0005, 0, 16'h0000, 16'h0000}); // -> DRAIN
        tv.push_back('{0, 0, 16'h0000, 0, 1, 16'h0005, 0, 16'h0000, 16'h0000});
        tv.push_back('{0, 0, 16'h0000, 1, 1, 16'h0005, 0, 16'h0000, 16'h0000}); // 0x105 discarded
        tv.push_back('{0, 0, 16'h0000, 1, 1, 16'h0040, 1, 16'h0140, 16'h0041});
        tv.push_back('{1, 1, 16'h0010, 1, 1, 16'h0041, 0, 16'h0000, 16'h0000}); // br beats freeze
        tv.push_back('{0, 0, 16'h0000, 1, 1, 16'h0010, 1, 16'h0110, 16'h0011});
        tv.push_back('{1, 0, 16'h0000, 1, 1, 16'h0011, 1, 16'h0110, 16'h0011}); // -> STALL
        tv.push_back('{1, 1, 16'h0020, 0, 0, 16'h0012, 0, 16'h0000, 16'h0000}); // br in STALL
        tv.push_back('{0, 0, 16'h0000, 1, 1, 16'h0020, 1, 16'h0120, 16'h0021});
        tv.push_back('{0, 1, 16'h0030, 0, 1, 16'h0021, 0, 16'h0000, 16'h0000}); // -> DRAIN
        tv.push_back('{0, 1, 16'h0050, 0, 1, 16'h0021, 0, 16'h0000, 16'h0000}); // br in DRAIN
        tv.push_back('{0, 0, 16'h0000, 1, 1, 16'h0021, 0, 16'h0000, 16'h0000});
        tv.push_back('{0, 0, 16'h0000, 1, 1, 16'h0050, 1, 16'h0150, 16'h0051});
        tv.push_back('{0, 1, 16'hFFFE, 1, 1, 16'h0051, 0, 16'h0000, 16'h0000}); // wrap
        tv.push_back('{0, 0, 16'h0000, 1, 1, 16'hFFFE, 1, 16'h00FE, 16'hFFFF});
        tv.push_back('{0, 0, 16'h0000, 1, 1, 16'hFFFF, 1, 16'h00FF, 16'h0000});
        tv.push_back('{0, 0, 16'h0000, 1, 1, 16'h0000, 1, 16'h0100, 16'h0001});
        tv.push_back('{1, 0, 16'h0000, 0, 1, 16'h0001, 1, 16'h0100, 16'h0001}); // freeze, not ready
        tv.push_back('{0, 0, 16'h0000, 1, 1, 16'h0001, 1, 16'h0101, 16'h0002});

        #2;
        check("rst imem_req", -1, {31'd0, imem_req}, 32'd0);
        check("rst imem_addr", -1, {16'd0, imem_addr}, 32'd0);
        check("rst valid_out", -1, {31'd0, valid_out}, 32'd0);
        check("rst instruction_out", -1, {16'd0, instruction_out}, 32'd0);
        check("rst pc_out", -1, {16'd0, pc_out}, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < tv.size(); i++) step(i, tv[i]);

        // Reset pulsed while draining a squashed request.
        freeze = 1'b0; br_taken = 1'b1; br_addr = 16'h0077; imem_ready = 1'b0;
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("mid-drain rst imem_req", 100, {31'd0, imem_req}, 32'd0);
        check("mid-drain rst imem_addr", 100, {16'd0, imem_addr}, 32'd0);
        check("mid-drain rst valid_out", 100, {31'd0, valid_out}, 32'd0);
        check("mid-drain rst instruction_out", 100, {16'd0, instruction_out}, 32'd0);
        check("mid-drain rst pc_out", 100, {16'd0, pc_out}, 32'd0);
        @(negedge clk);
        rst = 1'b1; br_taken = 1'b0; br_addr = '0; imem_ready = 1'b1;
        step(101, '{0, 0, 16'h0000, 1, 0, 16'h0000, 0, 16'h0000, 16'h0000});
        step(102, '{0, 0, 16'h0000, 1, 1, 16'h0000, 1, 16'h0100, 16'h0001});
        step(103, '{0, 0, 16'h0000, 1, 1, 16'h0001, 1, 16'h0101, 16'h0002});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
